data_memory_pipelined: RTL and testbench

Parametrised, clocked data memory for the MIPS pipeline MEM stage. It replaces the combinational 16x128 array with a synchronous single-port RAM that adds the following:
- valid/ready request handshake
- configurable read latency
- byte-enable stores
- out-of-range error reporting
- a hardware clear sequence after reset
All requests complete in order, one response per accepted request.

---
 rtl/data_memory_pipelined.sv | 116 +++++++++++
 tb/tb_data_memory_pipelined.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_pipelined.sv
// Synchronous single-port data memory for the MEM stage: valid/ready requests,
// byte-enable stores, range checking, LAT-cycle read pipeline and a zero-fill after reset.
module data_memory_pipelined #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 128,
    parameter int LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic ST_INIT  = 1'b0;
    localparam logic ST_READY = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);
    // One extra bit so DEPTH itself is representable even when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic                 state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [DATA_W-1:0]    mem_r [DEPTH];

    logic                 accept_s;
    logic                 in_range_s;
    logic [CNT_W-1:0]     idx_s;
    logic [DATA_W-1:0]    rd_s;

    logic [LAT-1:0]       vld_r;
    logic [LAT-1:0]       err_r;
    logic [DATA_W-1:0]    dat_r [LAT];

    // Request decode: accept qualification, full-width range check, read mux.
    always_comb begin
        accept_s   = req_valid && (state_r == ST_READY);
        in_range_s = ({1'b0, req_addr} < DEPTH_EXT);
        idx_s      = req_addr[CNT_W-1:0];
        if (in_range_s && !req_we) begin
            rd_s = mem_r[idx_s];
        end else begin
            rd_s = {DATA_W{1'b0}};
        end
    end

    // Clear-sequence FSM: walk every word once, then stay ready until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_READY;
                    end
                end
                ST_READY: state_r <= ST_READY;
                default:  state_r <= ST_INIT;
            endcase
        end
    end

    // RAM array: zero-fill during INIT, byte-masked in-range stores afterwards.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            mem_r[cnt_r] <= {DATA_W{1'b0}};
        end else if (accept_s && req_we && in_range_s) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) begin
                    mem_r[idx_s][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures at accept, LAT-1 further stages follow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= {LAT{1'b0}};
            err_r <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                dat_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            vld_r[0] <= accept_s;
            err_r[0] <= accept_s && !in_range_s;
            dat_r[0] <= accept_s ? rd_s : {DATA_W{1'b0}};
            for (int i = 1; i < LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
                err_r[i] <= err_r[i-1];
                dat_r[i] <= dat_r[i-1];
            end
        end
    end

    assign req_ready = (state_r == ST_READY);
    assign busy      = (state_r == ST_INIT);
    assign rsp_valid = vld_r[LAT-1];
    assign rsp_err   = err_r[LAT-1];
    assign rsp_rdata = dat_r[LAT-1];

endmodule

// File: tb/tb_data_memory_pipelined.sv
// Bench for data_memory_pipelined: three instances (LAT=1,2,3) share one stimulus
// stream; a scoreboard queue holds expected responses with their accept cycle.
module tb_data_memory_pipelined;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 128;
    localparam int NI    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              req_valid;
    logic              req_we;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic [DW/8-1:0]   req_be;
    logic [NI-1:0]     req_ready_v;
    logic [NI-1:0]     rsp_valid_v;
    logic [NI-1:0]     rsp_err_v;
    logic [NI-1:0]     busy_v;
    logic [DW-1:0]     rdata_v [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_memory_pipelined #(
            .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LAT(g + 1)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_valid(req_valid),
            .req_ready(req_ready_v[g]),
            .req_we   (req_we),
            .req_addr (req_addr),
            .req_wdata(req_wdata),
            .req_be   (req_be),
            .rsp_valid(rsp_valid_v[g]),
            .rsp_rdata(rdata_v[g]),
            .rsp_err  (rsp_err_v[g]),
            .busy     (busy_v[g])
        );
    end

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        int            acc;
    } sb_t;

    sb_t           sb[$];
    int            rp [NI];
    int            cyc;
    int            n_pass;
    int            n_chk;
    logic [DW-1:0] mdl [DEPTH];
    logic          exp_ready;
    int            init_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Compare every instance against the model after each clock edge.
    task automatic monitor();
        string p;
        for (int k = 0; k < NI; k++) begin
            p = $sformatf("lat%0d", k + 1);
            check({p, "_ready"}, 32'(req_ready_v[k]), 32'(exp_ready));
            check({p, "_busy"},  32'(busy_v[k]),      32'(!exp_ready));
            if (rsp_valid_v[k]) begin
                if (rp[k] < sb.size()) begin
                    check({p, "_rdata"}, 32'(rdata_v[k]), 32'(sb[rp[k]].d));
                    check({p, "_err"},   32'(rsp_err_v[k]), 32'(sb[rp[k]].e));
                    check({p, "_lat"},   32'(cyc - sb[rp[k]].acc), 32'(k));
                    rp[k]++;
                end else begin
                    check({p, "_spurious"}, 32'(rsp_valid_v[k]), 32'd0);
                end
            end else begin
                check({p, "_idle"}, 32'({rsp_err_v[k], rdata_v[k]}), 32'd0);
                while (rp[k] < sb.size() && (cyc - sb[rp[k]].acc) > k) begin
                    check({p, "_lost"}, 32'(rsp_valid_v[k]), 32'd1);
                    rp[k]++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n && !exp_ready) begin
            init_cnt++;
            if (init_cnt == DEPTH) exp_ready = 1'b1;
        end
        monitor();
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW/8-1:0] be);
        sb_t  e;
        logic inr;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        if (exp_ready) begin
            inr   = (a < DEPTH);
            e.acc = cyc + 1;
            e.e   = !inr;
            e.d   = (!we && inr) ? mdl[a[6:0]] : 16'h0000;
            sb.push_back(e);
            if (we && inr) begin
                for (int b = 0; b < DW / 8; b++) begin
                    if (be[b]) mdl[a[6:0]][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
        step();
        req_valid = 1'b0;
    endtask

    // Run the clear sequence while presenting an (ignored) load every cycle.
    task automatic run_init();
        int guard;
        guard = 0;
        while (!exp_ready && guard < 300) begin
            issue(1'b0, 16'd5, 16'h0000, 2'b00);
            guard++;
        end
        idle(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("lat%0d_rst_valid", k + 1), 32'(rsp_valid_v[k]), 32'd0);
            check($sformatf("lat%0d_rst_busy", k + 1),  32'(busy_v[k]),      32'd1);
            check($sformatf("lat%0d_rst_ready", k + 1), 32'(req_ready_v[k]), 32'd0);
        end
        exp_ready = 1'b0;
        init_cnt  = 0;
        for (int k = 0; k < NI; k++) rp[k] = sb.size();
        for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h0000;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        req_be    = 2'b00;
        cyc       = 0;
        n_pass    = 0;
        n_chk     = 0;
        exp_ready = 1'b0;
        init_cnt  = 0;
        for (int k = 0; k < NI; k++) rp[k] = 0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 16'h0000;

        // Reset state and clear sequence, then a load of cleared memory.
        idle(1);
        do_reset();
        run_init();
        issue(1'b0, 16'd5, 16'h0000, 2'b00);
        idle(4);

        // Store then immediate load; byte-enable merging; be=00 writes nothing.
        issue(1'b1, 16'd0, 16'hF0AA, 2'b11);
        issue(1'b0, 16'd0, 16'h0000, 2'b00);
        issue(1'b1, 16'd3, 16'hFFFF, 2'b11);
        issue(1'b1, 16'd3, 16'h1234, 2'b01);
        issue(1'b0, 16'd3, 16'h0000, 2'b00);
        issue(1'b1, 16'd3, 16'h5678, 2'b00);
        issue(1'b0, 16'd3, 16'h0000, 2'b00);
        issue(1'b1, 16'd127, 16'hA55A, 2'b10);
        issue(1'b0, 16'd127, 16'h0000, 2'b00);
        idle(4);

        // Back-to-back loads through every latency.
        issue(1'b1, 16'd1, 16'h1111, 2'b11);
        issue(1'b1, 16'd2, 16'h2222, 2'b11);
        issue(1'b1, 16'd3, 16'h3333, 2'b11);
        issue(1'b0, 16'd1, 16'h0000, 2'b00);
        issue(1'b0, 16'd2, 16'h0000, 2'b00);
        issue(1'b0, 16'd3, 16'h0000, 2'b00);
        idle(5);

        // Out of range: no write, no aliasing onto the low address bits.
        issue(1'b1, 16'd200, 16'hBEEF, 2'b11);
        issue(1'b0, 16'd200, 16'h0000, 2'b00);
        issue(1'b0, 16'd72, 16'h0000, 2'b00);
        issue(1'b1, 16'd128, 16'hCAFE, 2'b11);
        issue(1'b0, 16'd0, 16'h0000, 2'b00);
        issue(1'b0, 16'hFFFF, 16'h0000, 2'b00);
        idle(5);

        // Random traffic around the range boundary.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                idle(1);
            end else begin
                issue(1'($urandom_range(0, 1)), 16'($urandom_range(0, 140)),
                      16'($urandom), 2'($urandom_range(0, 3)));
            end
        end
        idle(5);

        // Reset while loads are in flight: drop them, clear memory again.
        issue(1'b1, 16'd9, 16'hABCD, 2'b11);
        issue(1'b0, 16'd9, 16'h0000, 2'b00);
        issue(1'b0, 16'd9, 16'h0000, 2'b00);
        idle(1);
        do_reset();
        run_init();
        issue(1'b0, 16'd9, 16'h0000, 2'b00);
        issue(1'b0, 16'd0, 16'h0000, 2'b00);
        idle(6);

        for (int k = 0; k < NI; k++) begin
            check($sformatf("lat%0d_drain", k + 1), 32'(rp[k]), 32'(sb.size()));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
